// File: rtl/regfile_writeback_queue_pkg.sv
// ----------------------------------------------------------------------------
// regfile_writeback_queue_pkg
//   Shared widths and the writeback entry type used by the writeback queue
//   and its bypass matcher.
//   ADDR_W     : register index width (32 architectural registers)
//   DATA_W     : register data width
//   REG_ZERO   : index of the hard-wired zero register
//   wb_entry_t : one pending writeback {destination register, data}
// ----------------------------------------------------------------------------
package regfile_writeback_queue_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [ADDR_W-1:0] regNum;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   localparam wb_entry_t ENTRY_ZERO = '{regNum: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};

endpackage : regfile_writeback_queue_pkg

// File: rtl/regfile_writeback_queue_bypass_match.sv
// ----------------------------------------------------------------------------
// wbq_bypass_match
//   DEPTH-way priority match of a read index against the pending writeback
//   entries. Entries are presented in age order (index 0 = oldest), and the
//   newest valid entry whose destination equals idx wins.
//   Ports:
//     idx        in   read index to look up
//     entries    in   pending entries, oldest at index 0
//     entryValid in   per-entry valid mask (same ordering as entries)
//     hit        out  some valid entry targets idx
//     data       out  data of the newest matching entry (0 when no hit)
// ----------------------------------------------------------------------------
module wbq_bypass_match
   import regfile_writeback_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic [ADDR_W-1:0]      idx,
   input  wb_entry_t [DEPTH-1:0]  entries,
   input  logic [DEPTH-1:0]       entryValid,
   output logic                   hit,
   output logic [DATA_W-1:0]      data
);

   logic [DEPTH-1:0] match_s;

   // Scan oldest to newest so that a later (newer) match overrides an older one.
   always_comb begin
      hit     = 1'b0;
      data    = {DATA_W{1'b0}};
      match_s = {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         match_s[k] = entryValid[k] && (entries[k].regNum == idx);
         hit        = hit | match_s[k];
         data       = match_s[k] ? entries[k].data : data;
      end
   end

endmodule : wbq_bypass_match

// File: rtl/regfile_writeback_queue.sv
// ----------------------------------------------------------------------------
// regfile_writeback_queue
//   Buffers writeback requests from the execute stage and drains them into
//   the register-file write port, one per cycle, in arrival order. Values
//   still waiting in the queue are forwarded onto both read-operand paths so
//   readers always observe the newest architectural value.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     in_valid/in_ready          writeback request handshake
//     in_reg/in_data             writeback destination and data ($zero dropped)
//     drain_en                   allows a register-file write this cycle
//     RegWrite/WriteRegister/
//     WriteData                  register-file write port (head entry)
//     ReadRegister1/2            operand indices (also feed the register file)
//     ReadData1/2                raw register-file read data
//     Operand1/2                 forwarded operand values
//     count                      current queue occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module regfile_writeback_queue
   import regfile_writeback_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_W-1:0]          in_reg,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       drain_en,
   output logic                       RegWrite,
   output logic [ADDR_W-1:0]          WriteRegister,
   output logic [DATA_W-1:0]          WriteData,
   input  logic [ADDR_W-1:0]          ReadRegister1,
   input  logic [ADDR_W-1:0]          ReadRegister2,
   input  logic [DATA_W-1:0]          ReadData1,
   input  logic [DATA_W-1:0]          ReadData2,
   output logic [DATA_W-1:0]          Operand1,
   output logic [DATA_W-1:0]          Operand2,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   wb_entry_t              mem_r [DEPTH];
   logic [PTR_W-1:0]       wrPtr_r;
   logic [PTR_W-1:0]       rdPtr_r;
   logic [CNT_W-1:0]       count_r;

   logic                   empty_s;
   logic                   inReady_s;
   logic                   push_s;
   logic                   pop_s;

   wb_entry_t [DEPTH-1:0]  ordered_s;
   logic [DEPTH-1:0]       orderedValid_s;

   logic                   hit1_s;
   logic                   hit2_s;
   logic [DATA_W-1:0]      fwd1_s;
   logic [DATA_W-1:0]      fwd2_s;

   // Handshake and drain qualifiers; a full queue never pushes, so push and
   // pop on the same edge always touch different slots.
   always_comb begin
      empty_s   = (count_r == CNT_ZERO);
      inReady_s = (count_r != CNT_FULL);
      push_s    = in_valid && inReady_s && (in_reg != REG_ZERO);
      pop_s     = drain_en && !empty_s;
   end

   // Queue storage: the accepted request lands in the slot at the write pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_r[k] <= ENTRY_ZERO;
         end
      end else if (push_s) begin
         mem_r[wrPtr_r] <= '{regNum: in_reg, data: in_data};
      end else begin
         mem_r[wrPtr_r] <= mem_r[wrPtr_r];
      end
   end

   // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_r <= {PTR_W{1'b0}};
         rdPtr_r <= {PTR_W{1'b0}};
         count_r <= CNT_ZERO;
      end else begin
         if (push_s) begin
            wrPtr_r <= wrPtr_r + PTR_ONE;
         end else begin
            wrPtr_r <= wrPtr_r;
         end

         if (pop_s) begin
            rdPtr_r <= rdPtr_r + PTR_ONE;
         end else begin
            rdPtr_r <= rdPtr_r;
         end

         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Present the pending entries oldest-first so the matcher can prefer the newest.
   always_comb begin
      ordered_s      = {DEPTH{ENTRY_ZERO}};
      orderedValid_s = {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         ordered_s[k]      = mem_r[rdPtr_r + PTR_W'(k)];
         orderedValid_s[k] = (CNT_W'(k) < count_r);
      end
   end

   wbq_bypass_match #(.DEPTH(DEPTH)) uBypass1 (
      .idx        (ReadRegister1),
      .entries    (ordered_s),
      .entryValid (orderedValid_s),
      .hit        (hit1_s),
      .data       (fwd1_s)
   );

   wbq_bypass_match #(.DEPTH(DEPTH)) uBypass2 (
      .idx        (ReadRegister2),
      .entries    (ordered_s),
      .entryValid (orderedValid_s),
      .hit        (hit2_s),
      .data       (fwd2_s)
   );

   // Register-file write port driven from the head entry; zeroed when nothing is pending.
   always_comb begin
      RegWrite = pop_s;
      if (empty_s) begin
         WriteRegister = {ADDR_W{1'b0}};
         WriteData     = {DATA_W{1'b0}};
      end else begin
         WriteRegister = mem_r[rdPtr_r].regNum;
         WriteData     = mem_r[rdPtr_r].data;
      end
   end

   // Operand 1 select: $zero reads as 0, then newest pending value, then the register file.
   always_comb begin
      if (ReadRegister1 == REG_ZERO) begin
         Operand1 = {DATA_W{1'b0}};
      end else if (hit1_s) begin
         Operand1 = fwd1_s;
      end else begin
         Operand1 = ReadData1;
      end
   end

   // Operand 2 select: same priority as operand 1.
   always_comb begin
      if (ReadRegister2 == REG_ZERO) begin
         Operand2 = {DATA_W{1'b0}};
      end else if (hit2_s) begin
         Operand2 = fwd2_s;
      end else begin
         Operand2 = ReadData2;
      end
   end

   assign in_ready = inReady_s;
   assign count    = count_r;

endmodule : regfile_writeback_queue

// File: tb/tb_regfile_writeback_queue.sv
module tb_regfile_writeback_queue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_reg;
   logic [31:0] in_data;
   logic        drain_en;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic [31:0] Operand1;
   logic [31:0] Operand2;
   logic [2:0]  count;

   ent_t expQ[$];
   int   errors = 0;
   int   checks = 0;
   bit   readyAtEdge = 1'b1;

   regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_reg        (in_reg),
      .in_data       (in_data),
      .drain_en      (drain_en),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2),
      .Operand1      (Operand1),
      .Operand2      (Operand2),
      .count         (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference forwarding: newest pending write to idx wins, $zero is always 0.
   function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] raw);
      if (idx == 5'd0) return 32'd0;
      for (int i = expQ.size() - 1; i >= 0; i--) begin
         if (expQ[i].r == idx) return expQ[i].d;
      end
      return raw;
   endfunction

   // Model: an accepted request to a nonzero register becomes a pending write.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         expQ.delete();
      end else if (in_valid && readyAtEdge && (in_reg != 5'd0)) begin
         expQ.push_back(ent_t'{in_reg, in_data});
      end
   end

   // Monitor: compare every visible output against the model mid-cycle.
   always @(negedge clk) begin
      int sz;
      bit expWr;
      sz    = expQ.size();
      expWr = rst_n && drain_en && (sz != 0);
      chk("count", 32'(count), 32'(sz));
      chk("in_ready", 32'(in_ready), 32'(sz != DEPTH));
      chk("RegWrite", 32'(RegWrite), 32'(expWr));
      chk("Operand1", Operand1, fwd(ReadRegister1, ReadData1));
      chk("Operand2", Operand2, fwd(ReadRegister2, ReadData2));
      if (sz == 0) begin
         chk("WriteRegister_empty", 32'(WriteRegister), 32'd0);
         chk("WriteData_empty", WriteData, 32'd0);
      end else begin
         chk("WriteRegister", 32'(WriteRegister), 32'(expQ[0].r));
         chk("WriteData", WriteData, expQ[0].d);
      end
      readyAtEdge = (sz != DEPTH);
      if (expWr) void'(expQ.pop_front());
   end

   task automatic step(input bit iv, input logic [4:0] ir, input logic [31:0] id,
                       input bit de, input logic [4:0] r1, input logic [4:0] r2);
      @(posedge clk);
      #1;
      in_valid      = iv;
      in_reg        = ir;
      in_data       = id;
      drain_en      = de;
      ReadRegister1 = r1;
      ReadRegister2 = r2;
      ReadData1     = $urandom;
      ReadData2     = $urandom;
   endtask

   initial begin
      rst_n         = 1'b0;
      in_valid      = 1'b1;
      in_reg        = 5'd5;
      in_data       = 32'hDEADBEEF;
      drain_en      = 1'b1;
      ReadRegister1 = 5'd5;
      ReadRegister2 = 5'd0;
      ReadData1     = 32'h11111111;
      ReadData2     = 32'h22222222;

      // 1: reset with a request held valid
      repeat (3) @(posedge clk);
      #1;
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      rst_n    = 1'b1;

      // 2: two entries, forwarded regardless of raw read data
      step(1'b1, 5'd1, 32'h0000FFFF, 1'b0, 5'd1, 5'd2);
      step(1'b1, 5'd2, 32'h8000FFFF, 1'b0, 5'd1, 5'd2);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd1, 5'd2);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd1, 5'd2);

      // 3: fill, hold a fifth request, then drain in order
      step(1'b1, 5'd3, 32'h33333333, 1'b0, 5'd3, 5'd4);
      step(1'b1, 5'd4, 32'h44444444, 1'b0, 5'd3, 5'd4);
      step(1'b1, 5'd5, 32'h55555555, 1'b0, 5'd4, 5'd5);
      step(1'b1, 5'd5, 32'h55555555, 1'b0, 5'd4, 5'd5);
      step(1'b1, 5'd5, 32'h55555555, 1'b1, 5'd1, 5'd5);
      step(1'b1, 5'd5, 32'h55555555, 1'b1, 5'd2, 5'd5);
      repeat (5) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd3);

      // 4: duplicate destinations, newest wins until both drain
      step(1'b1, 5'd3, 32'hAAAAAAAA, 1'b0, 5'd3, 5'd3);
      step(1'b1, 5'd3, 32'hFFFFFFFF, 1'b0, 5'd3, 5'd3);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd3);
      repeat (3) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3);

      // 5: writes to $zero are swallowed
      step(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);

      // 6: steady stream wrapping the pointers, then reset mid-stream
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 5'(1 + (i % 7)), $urandom, 1'b1, 5'(1 + (i % 7)), 5'(i % 3));
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("reset_midstream_RegWrite", 32'(RegWrite), 32'd0);
      chk("reset_midstream_count", 32'(count), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst_n    = 1'b1;

      // randomized traffic with small register indices to force duplicates
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end

      // drain what is left, bounded
      for (int i = 0; i < 3 * DEPTH && count != 3'd0; i++) begin
         step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
      end
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      @(negedge clk);
      #1;
      chk("final_model_empty", 32'(expQ.size()), 32'd0);
      chk("final_count", 32'(count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_regfile_writeback_queue
